// File: rtl/typedefs_pkg.sv
// Shared types for the register_bank -> mux -> alu datapath and its sequencer.
package typedefs_pkg;

   localparam int SEQ_AWIDTH = 3;
   localparam int SEQ_DWIDTH = 32;

   typedef enum logic [3:0] {
      AND  = 4'd0,
      OR   = 4'd1,
      XOR  = 4'd2,
      ADD  = 4'd3,
      SUB  = 4'd4,
      SLT  = 4'd5,
      SLTU = 4'd6,
      SLL  = 4'd7,
      SRL  = 4'd8,
      SRA  = 4'd9
   } aluop_sel_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2,
      RESP = 2'd3
   } seq_state_t;

   typedef struct packed {
      aluop_sel_t            op;
      logic [SEQ_AWIDTH-1:0] rd;
      logic [SEQ_AWIDTH-1:0] rs1;
      logic [SEQ_AWIDTH-1:0] rs2;
      logic [SEQ_DWIDTH-1:0] imm;
      logic                  use_imm;
   } alu_cmd_t;

endpackage

// File: rtl/alu_sequencer.sv
// One-command-at-a-time controller: reads operands, lets the ALU evaluate,
// writes the result back to rd and returns it on the response channel.
module alu_sequencer
   import typedefs_pkg::*;
#(
   parameter int AWIDTH = SEQ_AWIDTH,
   parameter int DWIDTH = SEQ_DWIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  aluop_sel_t        cmd_op,
   input  logic [AWIDTH-1:0] cmd_rd,
   input  logic [AWIDTH-1:0] cmd_rs1,
   input  logic [AWIDTH-1:0] cmd_rs2,
   input  logic [DWIDTH-1:0] cmd_imm,
   input  logic              cmd_use_imm,
   output logic [AWIDTH-1:0] raddr1,
   output logic [AWIDTH-1:0] raddr2,
   output logic              mux_sel,
   output logic [DWIDTH-1:0] imm_out,
   output aluop_sel_t        alu_sel,
   input  logic [DWIDTH-1:0] alu_res,
   input  logic              alu_res_is_0,
   output logic [AWIDTH-1:0] waddr,
   output logic [DWIDTH-1:0] wdata,
   output logic              wen,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DWIDTH-1:0] rsp_data,
   output logic              rsp_zero,
   output logic [15:0]       ops_done
);

   seq_state_t        state_r;
   alu_cmd_t          cmd_r;
   logic [DWIDTH-1:0] res_r;
   logic              res_zero_r;

   // The command latch doubles as the datapath control: it holds outside EXEC.
   assign raddr1   = cmd_r.rs1;
   assign raddr2   = cmd_r.rs2;
   assign mux_sel  = cmd_r.use_imm;
   assign imm_out  = cmd_r.imm;
   assign alu_sel  = cmd_r.op;
   assign waddr    = cmd_r.rd;
   assign wdata    = res_r;
   assign rsp_data = res_r;
   assign rsp_zero = res_zero_r;

   // Sequencer FSM; handshake and write-enable outputs are registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         cmd_r      <= '0;
         res_r      <= '0;
         res_zero_r <= 1'b0;
         cmd_ready  <= 1'b1;
         wen        <= 1'b0;
         rsp_valid  <= 1'b0;
         ops_done   <= 16'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (cmd_valid) begin
                  cmd_r.op      <= cmd_op;
                  cmd_r.rd      <= cmd_rd;
                  cmd_r.rs1     <= cmd_rs1;
                  cmd_r.rs2     <= cmd_rs2;
                  cmd_r.imm     <= cmd_imm;
                  cmd_r.use_imm <= cmd_use_imm;
                  cmd_ready     <= 1'b0;
                  state_r       <= EXEC;
               end
            end
            EXEC: begin
               res_r      <= alu_res;
               res_zero_r <= alu_res_is_0;
               // r0 is hardwired to zero, so a write to it is simply never issued.
               wen        <= (cmd_r.rd != '0);
               state_r    <= WB;
            end
            WB: begin
               wen       <= 1'b0;
               rsp_valid <= 1'b1;
               state_r   <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  ops_done  <= ops_done + 16'd1;
                  state_r   <= IDLE;
               end
            end
            default: begin
               wen       <= 1'b0;
               rsp_valid <= 1'b0;
               cmd_ready <= 1'b1;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench: a stand-in register bank and ALU close the loop around the
// sequencer, and a transaction-level model is compared against it every cycle.
module tb_alu_sequencer;
   import typedefs_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready;
   aluop_sel_t  cmd_op = AND;
   logic [2:0]  cmd_rd = 3'd0, cmd_rs1 = 3'd0, cmd_rs2 = 3'd0;
   logic [31:0] cmd_imm = 32'd0;
   logic        cmd_use_imm = 1'b0;
   logic [2:0]  raddr1, raddr2, waddr;
   logic        mux_sel, wen, rsp_valid, rsp_zero;
   logic        rsp_ready = 1'b1;
   logic [31:0] imm_out, alu_res, wdata, rsp_data;
   logic        alu_res_is_0;
   aluop_sel_t  alu_sel;
   logic [15:0] ops_done;

   int total = 0;
   int bad = 0;

   alu_sequencer #(.AWIDTH(3), .DWIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
      .cmd_imm(cmd_imm), .cmd_use_imm(cmd_use_imm),
      .raddr1(raddr1), .raddr2(raddr2), .mux_sel(mux_sel), .imm_out(imm_out),
      .alu_sel(alu_sel), .alu_res(alu_res), .alu_res_is_0(alu_res_is_0),
      .waddr(waddr), .wdata(wdata), .wen(wen),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_zero(rsp_zero), .ops_done(ops_done)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_f(input aluop_sel_t op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         AND:  return a & b;
         OR:   return a | b;
         XOR:  return a ^ b;
         ADD:  return a + b;
         SUB:  return a - b;
         SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         SLTU: return (a < b) ? 32'd1 : 32'd0;
         SLL:  return a << b[4:0];
         SRL:  return a >> b[4:0];
         SRA:  return $unsigned($signed(a) >>> b[4:0]);
         default: return 32'd0;
      endcase
   endfunction

   // Environment: register bank written by the DUT, combinational ALU.
   logic [31:0] env_regs [8];
   initial for (int i = 0; i < 8; i++) env_regs[i] = 32'd0;
   always @(posedge clk) if (wen) env_regs[waddr] <= wdata;

   function automatic logic [31:0] env_rd(input logic [2:0] a);
      return (a == 3'd0) ? 32'd0 : env_regs[a];
   endfunction

   always_comb begin
      alu_res      = alu_f(alu_sel, env_rd(raddr1), mux_sel ? imm_out : env_rd(raddr2));
      alu_res_is_0 = (alu_res == 32'd0);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: age -1 idle, 0 operand cycle, 1 write-back cycle, >=2 waiting on response.
   logic [31:0] m_regs [8];
   int          age = -1;
   logic [15:0] m_ops = 16'd0;
   aluop_sel_t  m_op;
   logic [2:0]  m_rd, m_rs1, m_rs2;
   logic [31:0] m_imm, m_res;
   logic        m_ui;
   bit          pend = 1'b0;

   function automatic logic [31:0] m_rdreg(input logic [2:0] a);
      return (a == 3'd0) ? 32'd0 : m_regs[a];
   endfunction

   initial begin
      for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            age = -1; m_ops = 16'd0; pend = 1'b0;
         end else begin
            if (pend) begin
               if (m_rd != 3'd0) m_regs[m_rd] = m_res;
               pend = 1'b0;
            end
            chk("cmd_ready", 32'(cmd_ready), 32'(age < 0));
            chk("wen", 32'(wen), 32'(age == 1 && m_rd != 3'd0));
            chk("rsp_valid", 32'(rsp_valid), 32'(age >= 2));
            chk("ops_done", 32'(ops_done), 32'(m_ops));
            if (age == 0) begin
               chk("raddr1", 32'(raddr1), 32'(m_rs1));
               if (!m_ui) chk("raddr2", 32'(raddr2), 32'(m_rs2));
               chk("mux_sel", 32'(mux_sel), 32'(m_ui));
               if (m_ui) chk("imm_out", imm_out, m_imm);
               chk("alu_sel", 32'(alu_sel), 32'(m_op));
            end
            if (age == 1 && m_rd != 3'd0) begin
               chk("waddr", 32'(waddr), 32'(m_rd));
               chk("wdata", wdata, m_res);
            end
            if (age >= 2) begin
               chk("rsp_data", rsp_data, m_res);
               chk("rsp_zero", 32'(rsp_zero), 32'(m_res == 32'd0));
            end
            if (age < 0) begin
               if (cmd_valid) begin
                  m_op = cmd_op; m_rd = cmd_rd; m_rs1 = cmd_rs1; m_rs2 = cmd_rs2;
                  m_imm = cmd_imm; m_ui = cmd_use_imm;
                  m_res = alu_f(m_op, m_rdreg(m_rs1), m_ui ? m_imm : m_rdreg(m_rs2));
                  age = 0;
               end
            end else if (age == 1) begin
               pend = 1'b1;
               age = 2;
            end else if (age >= 2 && rsp_ready) begin
               age = -1;
               m_ops = m_ops + 16'd1;
            end else begin
               age++;
            end
         end
      end
   end

   task automatic send(input aluop_sel_t op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [31:0] imm, input logic ui);
      int n;
      cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm; cmd_use_imm = ui;
      cmd_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         if (cmd_ready) break;
         n++;
         if (n > 50) begin chk("accept_timeout", 32'd0, 32'd1); break; end
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic get_rsp(output logic [31:0] d, output logic z);
      int n;
      rsp_ready = 1'b1;
      n = 0;
      d = 32'hDEADBEEF; z = 1'b0;
      forever begin
         @(negedge clk);
         if (rsp_valid) begin d = rsp_data; z = rsp_zero; break; end
         n++;
         if (n > 50) begin chk("rsp_timeout", 32'd0, 32'd1); break; end
      end
      @(posedge clk); #1;
   endtask

   logic [31:0] d;
   logic        z;

   initial begin
      int n;
      // Reset values while rst is held
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_wen", 32'(wen), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_ops_done", 32'(ops_done), 32'd0);
      chk("rst_alu_sel", 32'(alu_sel), 32'(AND));
      chk("rst_raddr1", 32'(raddr1), 32'd0);
      chk("rst_imm_out", imm_out, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      rst = 1'b0;

      send(ADD, 3'd1, 3'd0, 3'd0, 32'd5, 1'b1);
      get_rsp(d, z);
      chk("add_imm_data", d, 32'h5);
      chk("add_imm_zero", 32'(z), 32'd0);
      @(negedge clk);
      chk("ops_after_first", 32'(ops_done), 32'd1);
      @(posedge clk); #1;

      send(ADD, 3'd2, 3'd0, 3'd0, 32'd3, 1'b1);  get_rsp(d, z); chk("add_r2", d, 32'h3);
      send(SUB, 3'd3, 3'd2, 3'd1, 32'd0, 1'b0);  get_rsp(d, z); chk("sub_neg", d, 32'hFFFFFFFE);
      send(SLT, 3'd4, 3'd3, 3'd0, 32'd0, 1'b0);  get_rsp(d, z); chk("slt", d, 32'h1);
      send(SLTU, 3'd4, 3'd3, 3'd0, 32'd0, 1'b0); get_rsp(d, z); chk("sltu", d, 32'h0);
      send(SRA, 3'd5, 3'd3, 3'd0, 32'd4, 1'b1);  get_rsp(d, z); chk("sra", d, 32'hFFFFFFFF);
      send(SUB, 3'd6, 3'd1, 3'd1, 32'd0, 1'b0);  get_rsp(d, z);
      chk("zero_data", d, 32'h0);
      chk("zero_flag", 32'(z), 32'd1);
      send(XOR, 3'd0, 3'd1, 3'd0, 32'hF, 1'b1);  get_rsp(d, z); chk("xor_rd0", d, 32'hA);
      chk("r0_reads_zero", env_rd(3'd0), 32'd0);

      // Backpressure with a second command held by the producer
      rsp_ready = 1'b0;
      send(ADD, 3'd7, 3'd1, 3'd0, 32'd2, 1'b1);
      cmd_op = OR; cmd_rd = 3'd6; cmd_rs1 = 3'd1; cmd_rs2 = 3'd0; cmd_imm = 32'h30; cmd_use_imm = 1'b1;
      cmd_valid = 1'b1;
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
      repeat (5) begin
         @(negedge clk);
         chk("bp_rsp_data", rsp_data, 32'h7);
         chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_second_ready", 32'(cmd_ready), 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      get_rsp(d, z);
      chk("bp_second_data", d, 32'h35);
      @(negedge clk);
      chk("bp_ops_done", 32'(ops_done), 32'd10);
      @(posedge clk); #1;

      // Reset while the write-back is in flight
      send(ADD, 3'd1, 3'd0, 3'd0, 32'h99, 1'b1);
      n = 0;
      while (!wen && n < 20) begin @(negedge clk); n++; end
      chk("wb_wen_seen", 32'(wen), 32'd1);
      #2 rst = 1'b1;
      #1 chk("rst_wen_drop", 32'(wen), 32'd0);
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("post_rst_ops", 32'(ops_done), 32'd0);
      chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("r1_retained", env_regs[1], 32'h5);
      @(posedge clk); #1;

      send(ADD, 3'd2, 3'd1, 3'd0, 32'd1, 1'b1);
      get_rsp(d, z);
      chk("after_rst_cmd", d, 32'h6);
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
